// File: rtl/ring_stepper.sv
// One-hot ring stepper: a single active bit walks POSITIONS slots spaced STRIDE bits apart.
// Define RING_STEPPER_BOUNCE_EN to build the ping-pong (bounce) heading register and logic.
module ring_stepper #(
  parameter  int POSITIONS = 5,
  parameter  int STRIDE    = 3,
  parameter  int DIV       = 1,
  parameter  int INIT_IDX  = 0,
  localparam int W         = POSITIONS * STRIDE,
  localparam int IW        = (POSITIONS > 1) ? $clog2(POSITIONS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  input  logic          bounce,
  output logic [W-1:0]  count,
  output logic [IW-1:0] idx,
  output logic          wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(POSITIONS - 1);
  localparam logic [IW-1:0] RESET_IDX = IW'(INIT_IDX);
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);

  // Only bits at multiples of STRIDE can ever be set by construction.
  function automatic logic [W-1:0] onehot(input logic [IW-1:0] i);
    logic [W-1:0] v;
    v = '0;
    for (int p = 0; p < POSITIONS; p++) begin
      if (i == IW'(p)) v[p*STRIDE] = 1'b1;
    end
    return v;
  endfunction

  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          step;

`ifdef RING_STEPPER_BOUNCE_EN
  logic hd_q, hd_d;
`else
  logic unused_bounce;
  assign unused_bounce = bounce;
`endif

  always_comb begin
    idx_d  = idx_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    step   = 1'b0;
`ifdef RING_STEPPER_BOUNCE_EN
    hd_d   = hd_q;
`endif

    if (load) begin
      idx_d = (load_idx > LAST_IDX) ? LAST_IDX : load_idx;
      pre_d = '0;
`ifdef RING_STEPPER_BOUNCE_EN
      hd_d  = dir;
`endif
    end else if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    if (step) begin
`ifdef RING_STEPPER_BOUNCE_EN
      if (bounce) begin
        // Turnaround at an end slot moves one slot inward in the same step.
        if (!hd_q) begin
          if (idx_q == LAST_IDX) begin
            hd_d   = 1'b1;
            idx_d  = LAST_IDX - IW'(1);
            wrap_d = 1'b1;
          end else begin
            idx_d  = idx_q + IW'(1);
          end
        end else begin
          if (idx_q == '0) begin
            hd_d   = 1'b0;
            idx_d  = IW'(1);
            wrap_d = 1'b1;
          end else begin
            idx_d  = idx_q - IW'(1);
          end
        end
      end else
`endif
      begin
        if (!dir) begin
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d  = idx_q + IW'(1);
          end
        end else begin
          if (idx_q == '0) begin
            idx_d  = LAST_IDX;
            wrap_d = 1'b1;
          end else begin
            idx_d  = idx_q - IW'(1);
          end
        end
      end
    end

    count_d = onehot(idx_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= RESET_IDX;
      count_q <= onehot(RESET_IDX);
      wrap_q  <= 1'b0;
      pre_q   <= '0;
`ifdef RING_STEPPER_BOUNCE_EN
      hd_q    <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      pre_q   <= pre_d;
`ifdef RING_STEPPER_BOUNCE_EN
      hd_q    <= hd_d;
`endif
    end
  end

  assign count = count_q;
  assign idx   = idx_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_ring_stepper.sv
// Bench for ring_stepper: default instance plus a DIV=3 / INIT_IDX=2 instance on shared inputs.
// Honours RING_STEPPER_BOUNCE_EN for bounce expectations.
module tb_ring_stepper;

  logic clk = 1'b0;
  logic rst_n, en, dir, load, bounce;
  logic [2:0] load_idx;

  logic [14:0] c0, c1;
  logic [2:0]  i0, i1;
  logic        w0, w1;

  int errors = 0;
  int checks = 0;

  // Reference state per instance: slot, prescaler phase, heading, wrap flag.
  int m_idx[2];
  int m_pre[2];
  int m_hd[2];
  int m_wrap[2];
  int m_div[2]  = '{1, 3};
  int m_init[2] = '{0, 2};

  localparam int P = 5;

  always #5 clk = ~clk;

  ring_stepper #(.POSITIONS(5), .STRIDE(3), .DIV(1), .INIT_IDX(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_idx(load_idx), .bounce(bounce), .count(c0), .idx(i0), .wrap(w0)
  );

  ring_stepper #(.POSITIONS(5), .STRIDE(3), .DIV(3), .INIT_IDX(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_idx(load_idx), .bounce(bounce), .count(c1), .idx(i1), .wrap(w1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelUpdate();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_idx[k] = m_init[k]; m_pre[k] = 0; m_hd[k] = 0; m_wrap[k] = 0;
      end else if (load) begin
        m_idx[k]  = (int'(load_idx) >= P) ? P - 1 : int'(load_idx);
        m_pre[k]  = 0;
        m_wrap[k] = 0;
        m_hd[k]   = int'(dir);
      end else if (en && m_pre[k] < m_div[k] - 1) begin
        m_pre[k]++;
        m_wrap[k] = 0;
      end else if (en) begin
        m_pre[k] = 0;
`ifdef RING_STEPPER_BOUNCE_EN
        if (bounce) begin
          // Heading 0 climbs, 1 descends; hitting an end reverses and steps back in.
          if (m_hd[k] == 0 && m_idx[k] == P - 1) begin
            m_hd[k] = 1; m_idx[k] = P - 2; m_wrap[k] = 1;
          end else if (m_hd[k] == 1 && m_idx[k] == 0) begin
            m_hd[k] = 0; m_idx[k] = 1; m_wrap[k] = 1;
          end else begin
            m_idx[k]  = (m_hd[k] == 0) ? m_idx[k] + 1 : m_idx[k] - 1;
            m_wrap[k] = 0;
          end
        end else
`endif
        begin
          m_wrap[k] = (!dir && m_idx[k] == P - 1) || (dir && m_idx[k] == 0) ? 1 : 0;
          m_idx[k]  = dir ? (m_idx[k] + P - 1) % P : (m_idx[k] + 1) % P;
        end
      end else begin
        m_wrap[k] = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic d, input logic l,
                               input logic [2:0] li, input logic b);
    rst_n = r; en = e; dir = d; load = l; load_idx = li; bounce = b;
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check($sformatf("%s.count0", tag), 32'(c0), 32'd1 << (m_idx[0] * 3));
    check($sformatf("%s.idx0", tag),   32'(i0), 32'(m_idx[0]));
    check($sformatf("%s.wrap0", tag),  32'(w0), 32'(m_wrap[0]));
    check($sformatf("%s.count1", tag), 32'(c1), 32'd1 << (m_idx[1] * 3));
    check($sformatf("%s.idx1", tag),   32'(i1), 32'(m_idx[1]));
    check($sformatf("%s.wrap1", tag),  32'(w1), 32'(m_wrap[1]));
  endtask

  typedef struct {
    logic        rst_n, en, dir, load;
    logic [2:0]  load_idx;
    logic [14:0] exp_count;
    logic [2:0]  exp_idx;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[12];
  int   exp_bidx[10];
  int   exp_bwrap[10];

  initial begin
    int steps;
    int prev;

    // Expectations for the default instance (DIV=1, INIT_IDX=0).
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 15'h0001, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 15'h0008, 3'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 15'h0040, 3'd2, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 15'h0200, 3'd3, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 15'h1000, 3'd4, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 15'h0001, 3'd0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 15'h1000, 3'd4, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 15'h1000, 3'd4, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 15'h0200, 3'd3, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 15'h1000, 3'd4, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 15'h0200, 3'd3, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 15'h0001, 3'd0, 1'b0};

`ifdef RING_STEPPER_BOUNCE_EN
    exp_bidx  = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    exp_bwrap = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
`else
    exp_bidx  = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    exp_bwrap = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].rst_n, vecs[v].en, vecs[v].dir, vecs[v].load, vecs[v].load_idx, 1'b0);
      check($sformatf("vec%0d.count", v), 32'(c0), 32'(vecs[v].exp_count));
      check($sformatf("vec%0d.idx", v),   32'(i0), 32'(vecs[v].exp_idx));
      check($sformatf("vec%0d.wrap", v),  32'(w0), 32'(vecs[v].exp_wrap));
      checkOutput($sformatf("vec%0d", v));
    end

    // Prescaler on the DIV=3 instance: reset lands on slot 2.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    check("init_idx.count1", 32'(c1), 32'h0040);
    steps = 0;
    for (int c = 0; c < 6; c++) begin
      prev = int'(i1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
      if (int'(i1) != prev) steps++;
      checkOutput("pre6");
    end
    check("pre6.steps", 32'(steps), 32'd2);
    check("pre6.idx1", 32'(i1), 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      check("hold.idx1", 32'(i1), 32'd4);
      check("hold.wrap1", 32'(w1), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    check("resume1.idx1", 32'(i1), 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    check("resume2.idx1", 32'(i1), 32'd0);
    check("resume2.wrap1", 32'(w1), 32'd1);
    checkOutput("resume");

    // Load on a step-qualifying cycle clears the prescaler.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
    check("ldstep.count1", 32'(c1), 32'h0200);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    check("ldpre.idx1", 32'(i1), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    check("ldpre.step.idx1", 32'(i1), 32'd4);
    checkOutput("ldpre");

    // Bounce sequence on the default instance from slot 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int s = 0; s < 10; s++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
      check($sformatf("bounce%0d.idx0", s), 32'(i0), 32'(exp_bidx[s]));
      check($sformatf("bounce%0d.wrap0", s), 32'(w0), 32'(exp_bwrap[s]));
      checkOutput($sformatf("bounce%0d", s));
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      checkOutput($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_stepper.md
# ring_stepper

Parametrised one-hot ring stepper. It moves a single active bit through `POSITIONS` slots spaced `STRIDE` bits apart in a `POSITIONS*STRIDE`-bit output vector. It adds direction control, a step prescaler, a synchronous load and a wrap pulse. An optional bounce (ping-pong) mode is compiled in by macro. It drives the LED/segment scan and pacing chains in the midterm project datapath, and the defaults reproduce the existing 15-bit, stride-3, five-slot behaviour.

## Interface
- `POSITIONS`, 5: number of slots. Must be ≥2.
- `STRIDE`, 3: bit spacing between slots. Must be ≥1.
- `DIV`, 1: enabled cycles per step. Must be ≥1.
- `INIT_IDX`, 0: slot selected at reset. Must be < `POSITIONS`.
- Derived widths: `W = POSITIONS*STRIDE`; `IW = max(1, $clog2(POSITIONS))`.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `en  in  1`: advance qualifier; the prescaler counts only while high.
- `dir  in  1`: 0 = toward higher slot index, 1 = toward lower.
- `load  in  1`: synchronous load of `load_idx`.
- `load_idx  in  IW`: slot to load; values ≥ `POSITIONS` clamp to `POSITIONS-1`.
- `bounce  in  1`: selects ping-pong mode. Ignored when the macro is undefined.
- `count  out  W`: registered one-hot vector; bit `idx*STRIDE` is set, all other bits are 0.
- `idx  out  IW`: registered current slot index.
- `wrap  out  1`: registered one-cycle pulse on a wrap or turnaround step.

## Operation
- State: `idx`, prescaler `pre` (0..DIV-1), heading `hd` (bounce build only), and the `count` and `wrap` registers.
- Priority at each edge: `!rst_n` > `load` > step > hold.
- Reset values:
  - `idx = INIT_IDX`
  - `count = 1 << (INIT_IDX*STRIDE)`
  - `wrap = 0`, `pre = 0`, `hd = 0`
- Load:
  - `idx` ← clamp(`load_idx`), and `count` follows.
  - `pre` ← 0, `wrap` ← 0, `hd` ← `dir`.
  - `en` is ignored in the load cycle.
- Prescaler:
  - With `en=1` and `pre<DIV-1`, `pre` increments and no step occurs.
  - With `en=1` and `pre==DIV-1`, `pre` ← 0 and a step occurs.
  - With `en=0`, `pre`, `idx` and `count` hold.
- Ring step, `dir=0`: `idx` ← `idx+1`. From `POSITIONS-1` it goes to 0 and asserts `wrap`.
- Ring step, `dir=1`: `idx` ← `idx-1`. From 0 it goes to `POSITIONS-1` and asserts `wrap`.
- `wrap` is 1 only in the cycle after a wrapping step; it is 0 otherwise, including during hold.
- `dir` may change on any cycle and takes effect at the next step.
- Bounce step (`bounce=1`, macro defined):
  - `dir` is ignored and motion follows `hd`.
  - At an end slot with `hd` pointing outward, `hd` flips, `idx` moves one slot inward, and `wrap` is asserted.
  - Otherwise `idx` moves one slot per `hd`.
- Mode change: when `bounce` drops, ring stepping resumes per `dir` from the current `idx`, and `hd` keeps its value.
- `count` bits not at a multiple of `STRIDE` are never set in any state.

## Timing
- All outputs are registered, with zero combinational input-to-output paths.
- Step latency: the new `idx`, `count` and `wrap` are visible one cycle after the qualifying edge.
- Load latency: the loaded slot is visible on the next edge.
- Reset asserted mid-count takes effect on the next edge regardless of `en` or `load`.
- With `DIV=1` and `en` held high, the block steps every cycle.

## Configuration
- `RING_STEPPER_BOUNCE_EN` defined:
  - The `hd` register and ping-pong logic are compiled in.
  - The `bounce` input is honoured.
- `RING_STEPPER_BOUNCE_EN` undefined:
  - No `hd` register is built.
  - `bounce` is ignored, and behaviour is pure ring stepping per `dir`.

## Test plan
- Reset: `rst_n=0` for 1 cycle with defaults → `count=15'h0001`, `idx=0`, `wrap=0`. With `INIT_IDX=2` → `count=15'h0040`.
- Forward ring: `en=1`, `dir=0`, 5 cycles → `count` = `0008`, `0040`, `0200`, `1000`, `0001`. `wrap=1` only with `0001`.
- Reverse ring: from `idx=0`, `dir=1`, 1 step → `count=15'h1000`, `idx=4`, `wrap=1`.
- Prescaler: `DIV=3`, `en` high 6 cycles → exactly 2 steps. Dropping `en` for 4 cycles after `pre=1` holds state, and the step lands on the 2nd enabled cycle after `en` returns.
- Load:
  - `load=1`, `load_idx=3` concurrent with a step-qualifying `en` → `count=15'h0200`, `pre=0`.
  - `load_idx=7` → clamps to 4, giving `count=15'h1000`.
- Bounce (macro defined): `bounce=1` from `idx=0`, 10 steps → `idx` sequence 1,2,3,4,3,2,1,0,1,2. `wrap=1` on the 5th and 9th steps. Without the macro, the same stimulus produces ring wrapping.
